// File: rtl/round_robin_lock_arbiter.sv
// rtl/round_robin_lock_arbiter.sv - round-robin arbiter that locks a grant until the transaction ends
// Optional hold timeout forces release; one idle cycle separates consecutive owners.
module round_robin_lock_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       allow_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       done_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       busy_o,
  output logic                       timeout_o
);

  localparam int IW            = $clog2(NUM_REQ);
  localparam int HW            = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_LAST_INT = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_LAST_INT);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      gnt_idx_q, gnt_idx_d;
  logic               timeout_q, timeout_d;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic               rel_done, rel_wd, rel_to;
  logic [IW-1:0]      next_ptr;

  // Scan upward from ptr with wrap; the first set request wins.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  assign rel_done = done_i;
  assign rel_wd   = !req_i[gnt_idx_q];
  assign rel_to   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  assign next_ptr = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IW'(1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    timeout_d  = 1'b0;
    if (state_q == IDLE) begin
      if (allow_i && win_found) begin
        state_d    = BUSY;
        gnt_d      = NUM_REQ'(1) << win_idx;
        gnt_idx_d  = win_idx;
        hold_cnt_d = '0;
      end
    end else begin
      if (rel_done || rel_wd || rel_to) begin
        state_d   = IDLE;
        gnt_d     = '0;
        ptr_d     = next_ptr;
        timeout_d = rel_to && !rel_done && !rel_wd;
      end else if (hold_cnt_q != '1) begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = gnt_idx_q;
  assign busy_o    = (state_q == BUSY);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_round_robin_lock_arbiter.sv
// tb/tb_round_robin_lock_arbiter.sv - directed and soak bench for round_robin_lock_arbiter
module tb_round_robin_lock_arbiter;

  logic       clk_i = 1'b0;
  logic       arst_ni;
  logic       allow_i;
  logic [3:0] req_i;
  logic       done_i;
  logic [3:0] gnt_o;
  logic [1:0] gnt_idx_o;
  logic       busy_o;
  logic       timeout_o;

  int vectors    = 0;
  int miscompares = 0;

  // reference model state for the soak
  int m_busy, m_ptr, m_idx, m_cnt, m_to;
  int n_busy, n_ptr, n_idx, n_cnt, n_to;

  round_robin_lock_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .clk_i    (clk_i),
    .arst_ni  (arst_ni),
    .allow_i  (allow_i),
    .req_i    (req_i),
    .done_i   (done_i),
    .gnt_o    (gnt_o),
    .gnt_idx_o(gnt_idx_o),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                         input logic b, input logic to);
    chk({tag, ".gnt"}, 32'(gnt_o), 32'(g));
    chk({tag, ".idx"}, 32'(gnt_idx_o), 32'(idx));
    chk({tag, ".busy"}, 32'(busy_o), 32'(b));
    chk({tag, ".timeout"}, 32'(timeout_o), 32'(to));
  endtask

  initial begin
    // reset with random inputs, checked before any clock edge
    arst_ni = 1'b0;
    req_i   = 4'($urandom);
    allow_i = 1'($urandom);
    done_i  = 1'($urandom);
    #2;
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    arst_ni = 1'b1;
    req_i = 4'b0000; allow_i = 1'b0; done_i = 1'b0;

    // rotation from ptr=0 with all requesters active
    req_i = 4'b1111; allow_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("rot.grant", 4'b0001 << (k % 4), 2'(k % 4), 1'b1, 1'b0);
      tick();
      chk_out("rot.hold", 4'b0001 << (k % 4), 2'(k % 4), 1'b1, 1'b0);
      done_i = 1'b1;
      tick();
      chk_out("rot.idle", 4'b0000, 2'(k % 4), 1'b0, 1'b0);
      done_i = 1'b0;
    end
    req_i = 4'b0000;
    tick();

    // single grant to requester 2; ptr is 1 here
    req_i = 4'b0100;
    tick();
    chk_out("single.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("single.hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    done_i = 1'b1;
    tick();
    chk_out("single.release", 4'b0000, 2'd2, 1'b0, 1'b0);
    done_i = 1'b0;
    req_i  = 4'b0010;

    // timeout: ptr=3, scan 3,0,1 -> requester 1, held exactly 8 cycles
    tick();
    chk_out("to.grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int c = 1; c < 8; c++) begin
      tick();
      chk_out("to.hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    chk_out("to.release", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick();
    chk_out("to.regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
    req_i = 4'b0000;
    tick();
    chk_out("to.withdraw", 4'b0000, 2'd1, 1'b0, 1'b0);

    // allow gating then withdraw; ptr=2
    allow_i = 1'b0; req_i = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out("allow.blocked", 4'b0000, 2'd1, 1'b0, 1'b0);
    end
    allow_i = 1'b1;
    tick();
    chk_out("allow.grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    allow_i = 1'b0; req_i = 4'b1001;
    tick();
    chk_out("allow.ignored", 4'b1000, 2'd3, 1'b1, 1'b0);
    req_i = 4'b0000; allow_i = 1'b1;
    tick();
    chk_out("wd.release", 4'b0000, 2'd3, 1'b0, 1'b0);
    req_i = 4'b1111;
    tick();
    chk_out("wd.ptr_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

    // asynchronous reset mid-grant
    #2;
    arst_ni = 1'b0;
    #1;
    chk_out("midreset", 4'b0000, 2'd0, 1'b0, 1'b0);
    req_i = 4'b1010;
    #1;
    arst_ni = 1'b1;
    tick();
    chk_out("postreset", 4'b0010, 2'd1, 1'b1, 1'b0);

    // random soak against a reference model
    arst_ni = 1'b0; req_i = 4'b0000; allow_i = 1'b0; done_i = 1'b0;
    #2;
    arst_ni = 1'b1;
    m_busy = 0; m_ptr = 0; m_idx = 0; m_cnt = 0; m_to = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_i   = 4'($urandom) | 4'($urandom);
      allow_i = ($urandom_range(0, 3) != 0);
      done_i  = ($urandom_range(0, 9) == 0);
      n_busy = m_busy; n_ptr = m_ptr; n_idx = m_idx; n_cnt = m_cnt; n_to = 0;
      if (m_busy == 0) begin
        if (allow_i && (req_i != 0)) begin
          for (int i = 3; i >= 0; i--)
            if (req_i[(m_ptr + i) % 4]) n_idx = (m_ptr + i) % 4;
          n_busy = 1; n_cnt = 0;
        end
      end else if (done_i || !req_i[m_idx] || m_cnt == 7) begin
        n_busy = 0;
        n_ptr  = (m_idx + 1) % 4;
        n_to   = (!done_i && req_i[m_idx]) ? 1 : 0;
      end else begin
        n_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      end
      tick();
      m_busy = n_busy; m_ptr = n_ptr; m_idx = n_idx; m_cnt = n_cnt; m_to = n_to;
      chk("soak.gnt", 32'(gnt_o), (m_busy != 0) ? (32'd1 << m_idx) : 32'd0);
      chk("soak.idx", 32'(gnt_idx_o), 32'(m_idx));
      chk("soak.busy", 32'(busy_o), 32'(m_busy));
      chk("soak.timeout", 32'(timeout_o), 32'(m_to));
      chk("soak.onehot0", 32'($onehot0(gnt_o)), 32'd1);
      chk("soak.gnt_iff_busy", 32'(gnt_o != 4'b0000), 32'(busy_o));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
